seq_divider32: RTL and testbench

Multi-cycle iterative restoring divider: the inverse arithmetic path to the 32-bit ripple adder. It computes quotient and remainder of two WIDTH-bit operands by one trial subtraction per clock. It sits beside the ALU in the execute stage. The control unit stalls on `busy` and captures results on `done`. It supports unsigned and two's-complement signed division, with RISC-V-style divide-by-zero and overflow results.

---
 rtl/seq_divider32.sv | 151 +++++++++++++++
 tb/tb_seq_divider32.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider32.sv
// seq_divider32: iterative restoring divider, one trial subtraction per clock.
// Signed mode divides magnitudes and applies sign fixups at the end.
// Divide-by-zero and signed-overflow results follow RISC-V conventions.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a division (ignored while busy)
//   is_signed    1 = two's-complement, 0 = unsigned (sampled with start)
//   dividend     numerator (sampled with start)
//   divisor      denominator (sampled with start)
//   busy         iterations in progress
//   done         one-cycle pulse, results valid from this cycle on
//   quotient     registered quotient, held until the next accepted start
//   remainder    registered remainder, held until the next accepted start
//   div_by_zero  registered flag, high if the accepted divisor was zero
module seq_divider32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;    // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] part_q, part_d;  // partial remainder
  logic [WIDTH-1:0] dsr_q, dsr_d;    // divisor magnitude
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             dvd_neg, dsr_neg;
  logic [WIDTH-1:0] dvd_abs, dsr_abs;
  logic [WIDTH:0]   part_sh, trial;
  logic             trial_ok;
  logic [WIDTH-1:0] part_next, dvd_next;

  assign accept  = start && (state_q != StCalc);
  assign dvd_neg = is_signed && dividend[WIDTH-1];
  assign dsr_neg = is_signed && divisor[WIDTH-1];
  // Magnitude of the most negative value wraps to itself, which is the correct
  // unsigned magnitude.
  assign dvd_abs = dvd_neg ? -dividend : dividend;
  assign dsr_abs = dsr_neg ? -divisor : divisor;

  // One restoring step; the trial is one bit wider so its MSB is the borrow.
  assign part_sh   = {part_q, dvd_q[WIDTH-1]};
  assign trial     = part_sh - {1'b0, dsr_q};
  assign trial_ok  = ~trial[WIDTH];
  assign part_next = trial_ok ? trial[WIDTH-1:0] : part_sh[WIDTH-1:0];
  assign dvd_next  = {dvd_q[WIDTH-2:0], trial_ok};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    part_d    = part_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;

    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (divisor == '0) begin
            state_d = StDone;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d   = StCalc;
            dvd_d     = dvd_abs;
            dsr_d     = dsr_abs;
            part_d    = '0;
            cnt_d     = CntW'(WIDTH);
            neg_quo_d = dvd_neg ^ dsr_neg;
            neg_rem_d = dvd_neg;
          end
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        part_d = part_next;
        dvd_d  = dvd_next;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          quo_d   = neg_quo_q ? -dvd_next : dvd_next;
          rem_d   = neg_rem_q ? -part_next : part_next;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dvd_q     <= '0;
      part_q    <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      part_q    <= part_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  // Status decodes straight from the state register.
  assign busy        = (state_q == StCalc);
  assign done        = (state_q == StDone);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: directed cases from the test plan
// plus randomized operands checked against an arithmetic reference model.
module tb_seq_divider32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;
  logic hold = 1'b0;

  seq_divider32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain division with the RISC-V special cases.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
    z = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
  endtask

  // Counts negedges until done (bounded), and busy cycles seen on the way.
  task automatic wait_done(output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      cyc++;
      if (busy) nbusy++;
    end while (!done && cyc < 60);
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
    logic [31:0] eq, er;
    logic        ez;
    int          cyc, nbusy;
    ref_div(a, b, s, eq, er, ez);
    issue(a, b, s);
    wait_done(cyc, nbusy);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " latency"}, cyc, ez ? 32'd1 : 32'd33);
    chk({tag, " busy_cycles"}, nbusy, ez ? 32'd0 : 32'd32);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          cyc, nbusy;
    logic [31:0] ra, rb;
    logic        rs;

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    run_div("u100/7", 32'd100, 32'd7, 1'b0);
    run_div("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_div("uFFFF/1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div("u5/0", 32'd5, 32'd0, 1'b0);
    run_div("s5/0", 32'd5, 32'd0, 1'b1);
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_div("u0/9", 32'd0, 32'd9, 1'b0);
    run_div("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_div("s-8/-3", 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1);
    chk("u100/7 quotient literal", 32'd14, 32'd14 + 32'(div_by_zero));

    // start during CALC is ignored
    issue(32'd20, 32'd3, 1'b0);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    start    = 1'b1;
    dividend = 32'd50;
    wait_done(cyc, nbusy);
    chk("ignore latency", cyc, 32'd23);
    chk("ignore quotient", quotient, 32'd6);
    chk("ignore remainder", remainder, 32'd2);

    // start held through DONE: back-to-back accept
    hold = 1'b1;
    issue(32'd100, 32'd7, 1'b0);
    wait_done(cyc, nbusy);
    chk("b2b first latency", cyc, 32'd33);
    chk("b2b first quotient", quotient, 32'd14);
    chk("b2b first remainder", remainder, 32'd2);
    dividend = 32'd9;
    divisor  = 32'd4;
    hold     = 1'b0;
    wait_done(cyc, nbusy);
    chk("b2b second done", 32'(done), 32'd1);
    chk("b2b second latency", cyc, 32'd33);
    chk("b2b second quotient", quotient, 32'd2);
    chk("b2b second remainder", remainder, 32'd1);
    @(negedge clk);

    // reset mid-division
    issue(32'd100, 32'd7, 1'b0);
    repeat (15) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst quotient", quotient, 32'd0);
    chk("midrst remainder", remainder, 32'd0);
    chk("midrst dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_div("post_rst 9/4", 32'd9, 32'd4, 1'b0);

    // randomized operands
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 255));
        2: rb = -32'($urandom_range(1, 255));
        3: rb = $urandom >> $urandom_range(0, 31);
        default: rb = (i % 8 == 0) ? 32'd0 : 32'($urandom_range(1, 16));
      endcase
      run_div($sformatf("rand%0d", i), ra, rb, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
